lfsr_run_ctrl: RTL and testbench

//  Sequences a 16-bit maximal-length LFSR through one counting run: seed load, N steps, then done.

---
 rtl/lfsr_pkg.sv | 24 ++
 rtl/lfsr16_step.sv | 34 +++
 rtl/lfsr_run_ctrl.sv | 107 ++++++++++
 tb/tb_lfsr_run_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR constants, run-controller state encoding and the LFSR step function.
package lfsr_pkg;

  localparam int LFSR_W = 16;
  localparam int CNT_W  = 8;
  localparam int STEP_W = 16;

  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_NONZERO = 16'h0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16_step.sv
// 16-bit Fibonacci LFSR register with seed load (zero seed forced to 1) and step enable.
module lfsr16_step
  import lfsr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_en,
  input  logic [LFSR_W-1:0] i_seed,
  output logic [LFSR_W-1:0] o_state,
  output logic [LFSR_W-1:0] o_next
);

  logic [LFSR_W-1:0] r_state;
  logic [LFSR_W-1:0] w_next;
  logic [LFSR_W-1:0] w_seed_nz;

  assign w_next    = lfsr_next(r_state);
  assign w_seed_nz = (i_seed == '0) ? LFSR_NONZERO : i_seed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LFSR_NONZERO;
    end else if (i_load) begin
      r_state <= w_seed_nz;
    end else if (i_en) begin
      r_state <= w_next;
    end
  end

  assign o_state = r_state;
  assign o_next  = w_next;

endmodule

// File: rtl/lfsr_run_ctrl.sv
// Runs the LFSR from a seed for N steps, counting states that hit a masked pattern.
module lfsr_run_ctrl
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] MATCH_MASK = 16'h1FFE,
  parameter logic [LFSR_W-1:0] MATCH_PAT  = 16'h15F0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [LFSR_W-1:0] seed,
  input  logic [STEP_W-1:0] num_steps,
  output logic [LFSR_W-1:0] lfsr_reg,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              wrapped
);

  state_t            r_state;
  state_t            w_nxt;
  logic [LFSR_W-1:0] r_seed;
  logic [STEP_W-1:0] r_steps;
  logic [STEP_W-1:0] r_rem;
  logic [CNT_W-1:0]  r_count;
  logic              r_wrapped;
  logic              r_busy;
  logic              r_done;

  logic              w_load;
  logic              w_step;
  logic              w_hit;
  logic [LFSR_W-1:0] w_lfsr;
  logic [LFSR_W-1:0] w_lfsr_nxt;
  logic [LFSR_W-1:0] w_seed_nz;

  lfsr16_step u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_en    (w_step),
    .i_seed  (r_seed),
    .o_state (w_lfsr),
    .o_next  (w_lfsr_nxt)
  );

  assign w_load    = (r_state == ST_LOAD) && !abort;
  assign w_step    = (r_state == ST_RUN) && !abort;
  assign w_hit     = (w_lfsr & MATCH_MASK) == MATCH_PAT;
  assign w_seed_nz = (r_seed == '0) ? LFSR_NONZERO : r_seed;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_nxt = ST_LOAD;
      ST_LOAD: begin
        if (abort)               w_nxt = ST_IDLE;
        else if (r_steps == '0)  w_nxt = ST_DONE;
        else                     w_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (abort)                       w_nxt = ST_IDLE;
        else if (r_rem == STEP_W'(1))    w_nxt = ST_DONE;
      end
      ST_DONE: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  // busy/done come from the next state so they line up with r_state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_seed    <= '0;
      r_steps   <= '0;
      r_rem     <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= (w_nxt == ST_LOAD) || (w_nxt == ST_RUN);
      r_done  <= (w_nxt == ST_DONE);
      if (r_state == ST_IDLE && start) begin
        r_seed    <= seed;
        r_steps   <= num_steps;
        r_count   <= '0;
        r_wrapped <= 1'b0;
      end
      if (w_load) r_rem <= r_steps;
      if (w_step) begin
        r_rem <= r_rem - STEP_W'(1);
        if (w_hit && r_count != '1) r_count <= r_count + CNT_W'(1);
        if (w_lfsr_nxt == w_seed_nz) r_wrapped <= 1'b1;
      end
    end
  end

  assign lfsr_reg = w_lfsr;
  assign count    = r_count;
  assign busy     = r_busy;
  assign done     = r_done;
  assign wrapped  = r_wrapped;

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Scoreboard bench for lfsr_run_ctrl: randomized runs against a behavioural run model.
module tb_lfsr_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] seed;
  logic [15:0] num_steps;

  logic [15:0] lfsr_reg, s_lfsr;
  logic [7:0]  count, s_count;
  logic        busy, s_busy;
  logic        done, s_done;
  logic        wrapped, s_wrapped;

  lfsr_run_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .seed(seed), .num_steps(num_steps), .lfsr_reg(lfsr_reg),
    .count(count), .busy(busy), .done(done), .wrapped(wrapped)
  );

  lfsr_run_ctrl #(.MATCH_MASK(16'h0000), .MATCH_PAT(16'h0000)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .seed(seed), .num_steps(num_steps), .lfsr_reg(s_lfsr),
    .count(s_count), .busy(s_busy), .done(s_done), .wrapped(s_wrapped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    bit          dn;
    logic [15:0] lf;
    logic [7:0]  cn;
    logic [7:0]  sc;
    bit          wr;
  } exp_t;

  exp_t q[$];
  logic [15:0] m_lfsr = 16'h0001;

  // polynomial x^16+x^14+x^13+x^11+1, shifted left
  function automatic logic [15:0] poly_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic exp_t model(input logic [15:0] sd, input int n,
                                 input int ab, input int e0);
    exp_t e;
    int steps;
    logic [15:0] v0, v;
    int c;
    steps = (ab < 0) ? n : ((ab == 0) ? 0 : ab - 1);
    v0 = (sd == 16'h0) ? 16'h0001 : sd;
    v  = (ab == 0) ? m_lfsr : v0;
    c  = 0;
    e.wr = 1'b0;
    for (int i = 0; i < steps; i++) begin
      if ((v & 16'h1FFE) == 16'h15F0) c++;
      v = poly_step(v);
      if (v == v0) e.wr = 1'b1;
    end
    e.cyc = e0 + 2 + ((ab < 0) ? n : ab);
    e.dn  = (ab < 0);
    e.lf  = v;
    e.cn  = (c > 255) ? 8'd255 : 8'(c);
    e.sc  = (steps > 255) ? 8'd255 : 8'(steps);
    m_lfsr = v;
    return e;
  endfunction

  // ab: RUN cycle (1..n) to abort in, 0 = LOAD, -1 = none
  // ex: cycle offset for an extra (ignored) start, -1 = none
  task automatic run(input logic [15:0] sd, input int n,
                     input int ab, input int ex);
    int e0, endc;
    e0 = cyc;
    seed = sd;
    num_steps = 16'(n);
    start = 1'b1;
    abort = 1'($urandom_range(0, 1));
    q.push_back(model(sd, n, ab, e0));
    endc = e0 + 2 + ((ab < 0) ? n : ab);
    @(negedge clk);
    seed = 16'($urandom);
    num_steps = 16'($urandom);
    while (cyc < endc + 2) begin
      abort = (ab >= 0 && cyc == e0 + ab + 1) || (cyc == endc + 1);
      start = (ex >= 0 && cyc == e0 + ex);
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (done && prev_done)
        chk("done_one_cycle", {31'b0, done}, 32'd0);
      if (prev_busy && !busy) begin
        if (q.size() == 0) begin
          chk("unexpected_run_end", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("end_cycle", cyc, e.cyc);
          chk("done", {31'b0, done}, {31'b0, e.dn});
          chk("lfsr_reg", {16'b0, lfsr_reg}, {16'b0, e.lf});
          chk("count", {24'b0, count}, {24'b0, e.cn});
          chk("wrapped", {31'b0, wrapped}, {31'b0, e.wr});
          chk("sat_count", {24'b0, s_count}, {24'b0, e.sc});
        end
      end
    end
    prev_busy <= busy;
    prev_done <= done;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_lfsr"}, {16'b0, lfsr_reg}, 32'h0001);
    chk({tag, "_count"}, {24'b0, count}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_wrapped"}, {31'b0, wrapped}, 32'd0);
  endtask

  initial begin
    int n, ab, ex;
    logic [15:0] sd;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    seed = '0;
    num_steps = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    run(16'h15F0, 1, -1, -1);
    run(16'h15F1, 1, -1, -1);
    run(16'h1DF0, 1, -1, -1);
    run(16'h0000, 4, -1, -1);
    run(16'h1234, 300, -1, -1);
    run(16'($urandom), 10, 5, -1);
    run(16'h15F0, 10, -1, 5);
    run(16'hACE1, 0, -1, 1);
    run(16'h5555, 3, 0, -1);
    run(16'h15F0, 2, 2, -1);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: sd = 16'h0000;
        1: sd = 16'h15F0 | 16'($urandom_range(0, 1)) | 16'($urandom) & 16'hE000;
        default: sd = 16'($urandom);
      endcase
      n  = $urandom_range(0, 40);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : -1;
      ex = (ab < 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n + 2) : -1;
      run(sd, n, ab, ex);
    end

    // reset in the middle of a run
    seed = 16'hBEEF;
    num_steps = 16'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("midrun_reset");
    @(negedge clk);
    reset = 1'b0;
    m_lfsr = 16'h0001;
    @(negedge clk);

    run(16'h0001, 65535, -1, -1);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
